// File: rtl/intra16_mode_select.sv
// Intra 16x16 luma mode decision (vertical / horizontal / DC) by minimum SAD.
// Optional predicted-row output stage enabled by defining INTRA16_PRED_OUT_EN.
//
// state  | meaning
// IDLE   | waiting for start, inputs captured on start
// DCCALC | DC predictor computed from captured neighbours
// ACCUM  | 16 cycles, one macroblock row of SADs per cycle
// DECIDE | pick winner, register results
// EMIT   | (INTRA16_PRED_OUT_EN only) stream 16 predicted rows
module intra16_mode_select #(
    parameter int MB_SIZE_L = 16,
    parameter int MB_SIZE_W = 16,
    parameter int SAD_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           mb [0:MB_SIZE_L*MB_SIZE_W-1],
    input  logic [7:0]           toppixels [0:MB_SIZE_W-1],
    input  logic [7:0]           leftpixels [0:MB_SIZE_L-1],
    input  logic                 top_avail,
    input  logic                 left_avail,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           best_mode,
    output logic [SAD_WIDTH-1:0] best_sad,
    output logic [7:0]           dc_value
`ifdef INTRA16_PRED_OUT_EN
    ,
    output logic                 pred_valid,
    output logic [3:0]           pred_row_idx,
    output logic [7:0]           pred_row [0:MB_SIZE_W-1]
`endif
);

`ifdef INTRA16_PRED_OUT_EN
    typedef enum logic [2:0] {IDLE, DCCALC, ACCUM, DECIDE, EMIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, DCCALC, ACCUM, DECIDE} state_t;
`endif

    state_t state_q, state_d;

    logic [7:0]           mb_r   [0:MB_SIZE_L*MB_SIZE_W-1];
    logic [7:0]           top_r  [0:MB_SIZE_W-1];
    logic [7:0]           left_r [0:MB_SIZE_L-1];
    logic                 ta_r, la_r;
    logic [3:0]           row_cnt;
    logic [7:0]           dc_r;
    logic [SAD_WIDTH-1:0] sad_v, sad_h, sad_dc;
    logic [SAD_WIDTH-1:0] row_v, row_h, row_dc;
    logic [11:0]          sum_t, sum_l, half_sum;
    logic [12:0]          full_sum;
    logic [7:0]           dc_calc;
    logic [1:0]           dec_mode;
    logic [SAD_WIDTH-1:0] dec_sad;
`ifdef INTRA16_PRED_OUT_EN
    logic [3:0]           emit_cnt;
    logic [7:0]           pred_next [0:MB_SIZE_W-1];
`endif

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = DCCALC;
            DCCALC: state_d = ACCUM;
            ACCUM:  if (row_cnt == 4'd15) state_d = DECIDE;
`ifdef INTRA16_PRED_OUT_EN
            DECIDE: state_d = EMIT;
            EMIT:   if (emit_cnt == 4'd15) state_d = IDLE;
`else
            DECIDE: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // Operands are frozen at start so later input changes cannot disturb a decision.
    always_ff @(posedge clk) begin
        if (!reset && state_q == IDLE && start) begin
            mb_r   <= mb;
            top_r  <= toppixels;
            left_r <= leftpixels;
            ta_r   <= top_avail;
            la_r   <= left_avail;
        end
    end

    always_comb begin
        sum_t    = '0;
        sum_l    = '0;
        half_sum = '0;
        full_sum = '0;
        dc_calc  = 8'd128;
        for (int c = 0; c < MB_SIZE_W; c++) sum_t = sum_t + 12'(top_r[c]);
        for (int r = 0; r < MB_SIZE_L; r++) sum_l = sum_l + 12'(left_r[r]);
        if (ta_r && la_r) begin
            full_sum = 13'(sum_t) + 13'(sum_l) + 13'd16;
            dc_calc  = full_sum[12:5];
        end else if (ta_r) begin
            half_sum = sum_t + 12'd8;
            dc_calc  = half_sum[11:4];
        end else if (la_r) begin
            half_sum = sum_l + 12'd8;
            dc_calc  = half_sum[11:4];
        end
    end

    always_comb begin
        row_v  = '0;
        row_h  = '0;
        row_dc = '0;
        for (int c = 0; c < MB_SIZE_W; c++) begin
            row_v  = row_v  + SAD_WIDTH'(absdiff(mb_r[{row_cnt, 4'(c)}], top_r[c]));
            row_h  = row_h  + SAD_WIDTH'(absdiff(mb_r[{row_cnt, 4'(c)}], left_r[row_cnt]));
            row_dc = row_dc + SAD_WIDTH'(absdiff(mb_r[{row_cnt, 4'(c)}], dc_r));
        end
    end

    // Strict less-than gives tie priority DC, then vertical, then horizontal.
    always_comb begin
        dec_mode = 2'd2;
        dec_sad  = sad_dc;
        if (ta_r && sad_v < dec_sad) begin
            dec_mode = 2'd0;
            dec_sad  = sad_v;
        end
        if (la_r && sad_h < dec_sad) begin
            dec_mode = 2'd1;
            dec_sad  = sad_h;
        end
    end

`ifdef INTRA16_PRED_OUT_EN
    always_comb begin
        for (int c = 0; c < MB_SIZE_W; c++) begin
            case (best_mode)
                2'd0:    pred_next[c] = top_r[c];
                2'd1:    pred_next[c] = left_r[emit_cnt];
                default: pred_next[c] = dc_value;
            endcase
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt   <= '0;
            sad_v     <= '0;
            sad_h     <= '0;
            sad_dc    <= '0;
            dc_r      <= 8'd128;
            best_mode <= 2'd2;
            best_sad  <= '0;
            dc_value  <= 8'd128;
            done      <= 1'b0;
`ifdef INTRA16_PRED_OUT_EN
            emit_cnt     <= '0;
            pred_valid   <= 1'b0;
            pred_row_idx <= '0;
            pred_row     <= '{default: '0};
`endif
        end else begin
            done <= 1'b0;
`ifdef INTRA16_PRED_OUT_EN
            pred_valid <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        row_cnt <= '0;
                        sad_v   <= '0;
                        sad_h   <= '0;
                        sad_dc  <= '0;
                    end
                end
                DCCALC: dc_r <= dc_calc;
                ACCUM: begin
                    sad_v   <= sad_v + row_v;
                    sad_h   <= sad_h + row_h;
                    sad_dc  <= sad_dc + row_dc;
                    row_cnt <= row_cnt + 4'd1;
                end
                DECIDE: begin
                    best_mode <= dec_mode;
                    best_sad  <= dec_sad;
                    dc_value  <= dc_r;
`ifdef INTRA16_PRED_OUT_EN
                    emit_cnt  <= '0;
`else
                    done      <= 1'b1;
`endif
                end
`ifdef INTRA16_PRED_OUT_EN
                EMIT: begin
                    pred_valid   <= 1'b1;
                    pred_row_idx <= emit_cnt;
                    pred_row     <= pred_next;
                    emit_cnt     <= emit_cnt + 4'd1;
                    if (emit_cnt == 4'd15) done <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
